progmem_loader: RTL and testbench

Boot-time program loader for the single-cycle CPU. It receives a program as a byte stream over a valid/ready handshake and writes 16-bit instruction words into program memory through the memory's write port. It holds the CPU core in reset until the whole image is written. It sits beside the CPU top level and drives the write side of the same program memory that the core's fetch path reads.

---
 rtl/progmem_loader_if.sv | 28 ++
 rtl/progmem_loader.sv | 186 ++++++++++++++++++
 tb/tb_progmem_loader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/progmem_loader_if.sv
//------------------------------------------------------------------------------
// progmem_loader_if
// Byte-stream handshake and program-memory write-port interfaces.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface progmem_stream_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

interface progmem_wr_if #(
    parameter int AW = 10
);
    logic          pm_we;
    logic [AW-1:0] pm_addr;
    logic [15:0]   pm_wdata;

    modport master (output pm_we, output pm_addr, output pm_wdata);
    modport slave  (input  pm_we, input  pm_addr, input  pm_wdata);
endinterface

`default_nettype wire

// File: rtl/progmem_loader.sv
//------------------------------------------------------------------------------
// progmem_loader
// Boot-time loader: byte stream -> 16-bit program memory words, holds the CPU
// in reset until the image is complete. Optional trailing checksum byte is
// enabled with the PROGLOADER_CHECKSUM_EN macro.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module progmem_loader #(
    parameter int AW = 10
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          start,
    progmem_stream_if.slave    s,
    progmem_wr_if.master       pm,
    output logic               cpu_reset,
    output logic               done,
    output logic               error
);

    localparam logic [2:0] c_idle    = 3'd0;
    localparam logic [2:0] c_len_hi  = 3'd1;
    localparam logic [2:0] c_len_lo  = 3'd2;
    localparam logic [2:0] c_data_hi = 3'd3;
    localparam logic [2:0] c_data_lo = 3'd4;
    localparam logic [2:0] c_chk     = 3'd5;
    localparam logic [2:0] c_done    = 3'd6;
    localparam logic [2:0] c_err     = 3'd7;

    localparam logic [16:0] c_max_words = 17'(2**AW);

    logic [2:0]    r_state;
    logic [7:0]    r_len_hi;
    logic [7:0]    r_data_hi;
    logic [AW:0]   r_len;
    logic [AW:0]   r_cnt;
    logic          r_pm_we;
    logic [AW-1:0] r_pm_addr;
    logic [15:0]   r_pm_wdata;
    logic          r_cpu_reset;
    logic          r_done;
    logic          r_error;
`ifdef PROGLOADER_CHECKSUM_EN
    logic [7:0]    r_sum;
`endif

    logic          w_ready;
    logic          w_xfer;
    logic [15:0]   w_len;
    logic          w_len_bad;
    logic          w_last;

    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            c_len_hi, c_len_lo, c_data_hi, c_data_lo, c_chk: w_ready = 1'b1;
            default:                                          w_ready = 1'b0;
        endcase
    end

    assign w_xfer    = s.in_valid && w_ready;
    assign w_len     = {r_len_hi, s.in_data};
    assign w_len_bad = (w_len == 16'd0) || ({1'b0, w_len} > c_max_words);
    // r_cnt counts words already written, so +1 is the word being accepted now
    assign w_last    = ((r_cnt + (AW+1)'(1)) == r_len);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_idle;
            r_len_hi    <= 8'd0;
            r_data_hi   <= 8'd0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_pm_we     <= 1'b0;
            r_pm_addr   <= '0;
            r_pm_wdata  <= 16'd0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
`ifdef PROGLOADER_CHECKSUM_EN
            r_sum       <= 8'd0;
`endif
        end else begin
            r_pm_we <= 1'b0;
            // Address advances on the edge that closes the write cycle
            if (r_pm_we) begin
                r_pm_addr <= r_pm_addr + AW'(1);
            end

            case (r_state)
                c_idle, c_done, c_err: begin
                    if (start) begin
                        r_state     <= c_len_hi;
                        r_cnt       <= '0;
                        r_pm_addr   <= '0;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_cpu_reset <= 1'b1;
`ifdef PROGLOADER_CHECKSUM_EN
                        r_sum       <= 8'd0;
`endif
                    end
                end
                c_len_hi: begin
                    if (w_xfer) begin
                        r_len_hi <= s.in_data;
                        r_state  <= c_len_lo;
                    end
                end
                c_len_lo: begin
                    if (w_xfer) begin
                        if (w_len_bad) begin
                            r_state     <= c_err;
                            r_error     <= 1'b1;
                            r_cpu_reset <= 1'b1;
                        end else begin
                            r_len   <= w_len[AW:0];
                            r_state <= c_data_hi;
                        end
                    end
                end
                c_data_hi: begin
                    if (w_xfer) begin
                        r_data_hi <= s.in_data;
                        r_state   <= c_data_lo;
`ifdef PROGLOADER_CHECKSUM_EN
                        r_sum     <= r_sum + s.in_data;
`endif
                    end
                end
                c_data_lo: begin
                    if (w_xfer) begin
                        r_pm_we    <= 1'b1;
                        r_pm_wdata <= {r_data_hi, s.in_data};
                        r_cnt      <= r_cnt + (AW+1)'(1);
`ifdef PROGLOADER_CHECKSUM_EN
                        r_sum      <= r_sum + s.in_data;
`endif
                        if (w_last) begin
`ifdef PROGLOADER_CHECKSUM_EN
                            r_state     <= c_chk;
`else
                            r_state     <= c_done;
                            r_done      <= 1'b1;
                            r_cpu_reset <= 1'b0;
`endif
                        end else begin
                            r_state <= c_data_hi;
                        end
                    end
                end
`ifdef PROGLOADER_CHECKSUM_EN
                c_chk: begin
                    if (w_xfer) begin
                        if (s.in_data == r_sum) begin
                            r_state     <= c_done;
                            r_done      <= 1'b1;
                            r_cpu_reset <= 1'b0;
                        end else begin
                            r_state     <= c_err;
                            r_error     <= 1'b1;
                            r_cpu_reset <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign s.in_ready  = w_ready;
    assign pm.pm_we    = r_pm_we;
    assign pm.pm_addr  = r_pm_addr;
    assign pm.pm_wdata = r_pm_wdata;
    assign cpu_reset   = r_cpu_reset;
    assign done        = r_done;
    assign error       = r_error;

endmodule

`default_nettype wire

// File: tb/tb_progmem_loader.sv
//------------------------------------------------------------------------------
// tb_progmem_loader
// Directed self-checking bench for progmem_loader (AW = 10).
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_progmem_loader;

    localparam int AW = 10;

    logic clk;
    logic reset;
    logic start;
    logic cpu_reset;
    logic done;
    logic error;

    progmem_stream_if        st_if ();
    progmem_wr_if #(.AW(AW)) pm_if ();

    progmem_loader #(.AW(AW)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .s         (st_if.slave),
        .pm        (pm_if.master),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    int n_checks = 0;
    int n_fails  = 0;

    logic [AW-1:0] wr_addr[$];
    logic [15:0]   wr_data[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pm_if.pm_we === 1'b1) begin
            wr_addr.push_back(pm_if.pm_addr);
            wr_data.push_back(pm_if.pm_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, expv);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge
    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit ok;
        bit rdy;
        ok = 1'b0;
        st_if.in_valid = 1'b1;
        st_if.in_data  = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            rdy = st_if.in_ready;
            @(posedge clk);
            #1;
            if (rdy) ok = 1'b1;
        end
        st_if.in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_stream(input logic [7:0] q[$], input bit gap);
        foreach (q[i]) send_byte(q[i], gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_in_ready"},  32'(st_if.in_ready), 32'd0);
        check({tag, "_pm_we"},     32'(pm_if.pm_we),    32'd0);
        check({tag, "_pm_addr"},   32'(pm_if.pm_addr),  32'd0);
        check({tag, "_pm_wdata"},  32'(pm_if.pm_wdata), 32'd0);
        check({tag, "_cpu_reset"}, 32'(cpu_reset),      32'd1);
        check({tag, "_done"},      32'(done),           32'd0);
        check({tag, "_error"},     32'(error),          32'd0);
    endtask

    task automatic check_two_words(input string tag);
        check({tag, "_nwr"},   32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check({tag, "_a0"}, 32'(wr_addr[0]), 32'd0);
            check({tag, "_d0"}, 32'(wr_data[0]), 32'h1234);
            check({tag, "_a1"}, 32'(wr_addr[1]), 32'd1);
            check({tag, "_d1"}, 32'(wr_data[1]), 32'hABCD);
        end
    endtask

    logic [7:0] good_q[$];
    logic [7:0] bad_q[$];
    logic [7:0] bulk_q[$];
    logic [7:0] bulk_sum;
    logic [15:0] bulk_exp;
    int bulk_bad;

    initial begin
        reset = 1'b0;
        start = 1'b0;
        st_if.in_valid = 1'b0;
        st_if.in_data  = 8'h00;

        // 0x12+0x34+0xAB+0xCD = 0x1BE -> checksum byte 0xBE
        good_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        bad_q  = good_q;
`ifdef PROGLOADER_CHECKSUM_EN
        good_q.push_back(8'hBE);
        bad_q.push_back(8'hBF);
`endif

        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_reset("rst");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_outputs_reset("idle");

        // Basic load, back-to-back bytes
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        send_stream(good_q, 1'b0);
        check("basic_done",      32'(done),      32'd1);
        check("basic_cpu_reset", 32'(cpu_reset), 32'd0);
        check("basic_error",     32'(error),     32'd0);
        check("basic_in_ready",  32'(st_if.in_ready), 32'd0);
        @(negedge clk); @(negedge clk);
        check_two_words("basic");
        check("basic_addr_after", 32'(pm_if.pm_addr), 32'd2);

        // Same stream with in_valid toggling; start accepted from DONE
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        check("restart_done",      32'(done),      32'd0);
        check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
        send_stream(good_q, 1'b1);
        check("toggle_done",      32'(done),      32'd1);
        check("toggle_cpu_reset", 32'(cpu_reset), 32'd0);
        @(negedge clk); @(negedge clk);
        check_two_words("toggle");

        // Zero length
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        send_stream('{8'h00, 8'h00}, 1'b0);
        check("len0_error",     32'(error),     32'd1);
        check("len0_done",      32'(done),      32'd0);
        check("len0_cpu_reset", 32'(cpu_reset), 32'd1);
        @(negedge clk);
        check("len0_nwr",       32'(wr_addr.size()), 32'd0);

        // Reload after error
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        check("reload_error", 32'(error), 32'd0);
        send_stream(good_q, 1'b0);
        check("reload_done", 32'(done), 32'd1);
        @(negedge clk); @(negedge clk);
        check_two_words("reload");

        // Length one past capacity
        pulse_start();
        send_stream('{8'h04, 8'h01}, 1'b0);
        check("len401_error",     32'(error),     32'd1);
        check("len401_cpu_reset", 32'(cpu_reset), 32'd1);

        // Full capacity, address wraps to 0 afterwards
        bulk_q   = '{8'h04, 8'h00};
        bulk_sum = 8'h00;
        for (int i = 0; i < 1024; i++) begin
            bulk_q.push_back(8'(i));
            bulk_q.push_back(8'(i >> 2) ^ 8'hA5);
            bulk_sum = bulk_sum + 8'(i) + (8'(i >> 2) ^ 8'hA5);
        end
`ifdef PROGLOADER_CHECKSUM_EN
        bulk_q.push_back(bulk_sum);
`endif
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        send_stream(bulk_q, 1'b0);
        check("bulk_done", 32'(done), 32'd1);
        @(negedge clk); @(negedge clk);
        check("bulk_nwr", 32'(wr_addr.size()), 32'd1024);
        bulk_bad = 0;
        foreach (wr_addr[i]) begin
            bulk_exp = {8'(i), 8'(i >> 2) ^ 8'hA5};
            if (wr_addr[i] !== AW'(i) || wr_data[i] !== bulk_exp) bulk_bad++;
        end
        check("bulk_bad_words", 32'(bulk_bad), 32'd0);
        check("bulk_addr_wrap", 32'(pm_if.pm_addr), 32'd0);

`ifdef PROGLOADER_CHECKSUM_EN
        // Wrong checksum: words stay written, load fails
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        send_stream(bad_q, 1'b0);
        check("badchk_error",     32'(error),     32'd1);
        check("badchk_done",      32'(done),      32'd0);
        check("badchk_cpu_reset", 32'(cpu_reset), 32'd1);
        @(negedge clk);
        check_two_words("badchk");
`endif

        // Asynchronous reset mid-load, after the first word is written
        pulse_start();
        send_stream('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB}, 1'b0);
        check("mid_addr_before", 32'(pm_if.pm_addr), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_outputs_reset("async");
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        send_stream(good_q, 1'b0);
        check("after_rst_done", 32'(done), 32'd1);
        @(negedge clk); @(negedge clk);
        check_two_words("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
